// File: rtl/uart_pkg.sv
// Shared constants, register field positions and the TX state type for the UART
// transmit block.
package uart_pkg;

    localparam logic [2:0] ADDR_THR = 3'd0;
    localparam logic [2:0] ADDR_IER = 3'd1;
    localparam logic [2:0] ADDR_IIR = 3'd2;
    localparam logic [2:0] ADDR_LCR = 3'd3;
    localparam logic [2:0] ADDR_LSR = 3'd5;

    localparam int LCR_STB  = 2;
    localparam int LCR_PEN  = 3;
    localparam int LCR_EPS  = 4;
    localparam int LCR_DLAB = 7;

    localparam int LSR_OE   = 1;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam int IER_ETBEI = 1;

    localparam logic [7:0] IIR_THRE  = 8'h02;
    localparam logic [7:0] IIR_NONE  = 8'h01;
    localparam logic [7:0] LCR_RESET = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Parity over the active word-length bits; even mode makes data+parity even.
    function automatic logic tx_parity(input logic [7:0] data,
                                       input logic [1:0] wls,
                                       input logic       even);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - wls);
        return (^(data & mask)) ^ ~even;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO holding transmit data; depth is a power of two.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; only the pointers and count define validity,
    // which keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_wb_tx.sv
// Wishbone slave register file plus the serial transmitter (baud counter and
// frame FSM) of the UART TX path.
module uart_wb_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [4:0] wb_addr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic [3:0] wb_sel_i,
    input  logic       wb_we_i,
    input  logic       wb_stb_i,
    input  logic       wb_cyc_i,
    output logic       wb_ack_o,
    output logic       int_o,
    output logic       stx_pad_o
);

    logic       unused_bus;
    logic [2:0] addr;
    logic       req;
    logic       dlab;
    logic       thr_wr;
    logic       lsr_rd;
    logic [7:0] rdata;

    logic [7:0] ier_q;
    logic [7:0] lcr_q;
    logic [7:0] dll_q;
    logic [7:0] dlm_q;
    logic       overflow_q;

    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_data;
    logic       fifo_full;
    logic       fifo_empty;

    tx_state_t  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] period_q, period_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        par_q, par_d;
    logic [3:0]  frame_lcr_q, frame_lcr_d;
    logic        stx_q, stx_d;
    logic        load;

    logic [15:0] divisor;
    logic        halt;
    logic [19:0] period_live;
    logic        bit_done;
    logic        can_pop;

    assign unused_bus = ^{wb_sel_i, wb_addr_i[4:3]};

    assign addr   = wb_addr_i[2:0];
    assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign dlab   = lcr_q[LCR_DLAB];
    assign thr_wr = req & wb_we_i & (addr == ADDR_THR) & ~dlab;
    assign lsr_rd = req & ~wb_we_i & (addr == ADDR_LSR);

    assign fifo_push = thr_wr & ~fifo_full;
    assign int_o     = ier_q[IER_ETBEI] & fifo_empty;
    assign stx_pad_o = stx_q;

    always_comb begin
        rdata = 8'h00;
        case (addr)
            ADDR_THR: rdata = dlab ? dll_q : 8'h00;
            ADDR_IER: rdata = dlab ? dlm_q : ier_q;
            ADDR_IIR: rdata = int_o ? IIR_THRE : IIR_NONE;
            ADDR_LCR: rdata = lcr_q;
            ADDR_LSR: begin
                rdata[LSR_OE]   = overflow_q;
                rdata[LSR_THRE] = fifo_empty;
                rdata[LSR_TEMT] = fifo_empty & (state_q == IDLE);
            end
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= 8'h00;
            ier_q      <= 8'h00;
            lcr_q      <= LCR_RESET;
            dll_q      <= 8'h00;
            dlm_q      <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rdata : 8'h00;
            if (req && wb_we_i) begin
                case (addr)
                    ADDR_THR: begin
                        if (dlab)           dll_q      <= wb_dat_i;
                        else if (fifo_full) overflow_q <= 1'b1;
                    end
                    ADDR_IER: begin
                        if (dlab) dlm_q <= wb_dat_i;
                        else      ier_q <= wb_dat_i;
                    end
                    ADDR_LCR: lcr_q <= wb_dat_i;
                    default: ;
                endcase
            end else if (lsr_rd) begin
                overflow_q <= 1'b0;
            end
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_i),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (wb_dat_i),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign divisor     = {dlm_q, dll_q};
    assign halt        = (divisor == 16'd0);
    assign period_live = {divisor, 4'b0000};
    assign bit_done    = (cnt_q == period_q - 20'd1);
    assign can_pop     = ~fifo_empty & ~halt;
    assign fifo_pop    = load;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        par_d       = par_q;
        frame_lcr_d = frame_lcr_q;
        stx_d       = stx_q;
        load        = 1'b0;

        if (state_q == IDLE) begin
            stx_d = 1'b1;
            load  = can_pop;
        end else if (!halt) begin
            if (!bit_done) begin
                cnt_d = cnt_q + 20'd1;
            end else begin
                // Bit boundary: the period is re-sampled so divisor edits land here.
                cnt_d    = '0;
                period_d = period_live;
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        stx_d     = shift_q[0];
                    end
                    DATA: begin
                        if (bit_idx_q == {1'b1, frame_lcr_q[1:0]}) begin
                            if (frame_lcr_q[LCR_PEN]) begin
                                state_d = PARITY;
                                stx_d   = par_q;
                            end else begin
                                state_d   = STOP;
                                bit_idx_d = '0;
                                stx_d     = 1'b1;
                            end
                        end else begin
                            shift_d   = shift_q >> 1;
                            bit_idx_d = bit_idx_q + 3'd1;
                            stx_d     = shift_q[1];
                        end
                    end
                    PARITY: begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                        stx_d     = 1'b1;
                    end
                    STOP: begin
                        if (frame_lcr_q[LCR_STB] && bit_idx_q == 3'd0) begin
                            bit_idx_d = 3'd1;
                        end else if (can_pop) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            stx_d   = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        if (load) begin
            state_d     = START;
            cnt_d       = '0;
            period_d    = period_live;
            shift_d     = fifo_data;
            frame_lcr_d = lcr_q[3:0];
            par_d       = tx_parity(fifo_data, lcr_q[1:0], lcr_q[LCR_EPS]);
            stx_d       = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            par_q       <= 1'b0;
            frame_lcr_q <= 4'h3;
            stx_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            par_q       <= par_d;
            frame_lcr_q <= frame_lcr_d;
            stx_q       <= stx_d;
        end
    end

endmodule

// File: tb/tb_uart_wb_tx.sv
// Self-checking bench for uart_wb_tx: a frame-level reference model compared
// every cycle, plus directed register and waveform checks.
module tb_uart_wb_tx;
    import uart_pkg::*;

    localparam int FIFO_DEPTH = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] addr  = '0;
    logic [7:0] dat_i = '0;
    logic [7:0] dat_o;
    logic [3:0] sel   = 4'hF;
    logic       we    = 1'b0;
    logic       stb   = 1'b0;
    logic       cyc   = 1'b0;
    logic       ack;
    logic       irq;
    logic       stx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_wb_tx #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .wb_addr_i (addr),
        .wb_dat_i  (dat_i),
        .wb_dat_o  (dat_o),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_stb_i  (stb),
        .wb_cyc_i  (cyc),
        .wb_ack_o  (ack),
        .int_o     (irq),
        .stx_pad_o (stx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue, pending frame as a list of line levels.
    logic [7:0] m_q[$];
    logic       m_bits[$];
    logic       m_level = 1'b1;
    logic       m_busy  = 1'b0;
    logic       m_ack   = 1'b0;
    logic [7:0] m_ier   = 8'h00;
    logic [7:0] m_lcr   = 8'h03;
    logic [7:0] m_dll   = 8'h00;
    logic [7:0] m_dlm   = 8'h00;
    int         m_rem   = 0;

    function automatic void build_frame(input logic [7:0] b, input logic [7:0] lcr);
        int wl;
        int ones;
        wl   = 5 + int'(lcr[1:0]);
        ones = 0;
        m_bits.delete();
        for (int i = 0; i < wl; i++) begin
            m_bits.push_back(b[i]);
            ones += int'(b[i]);
        end
        if (lcr[3]) m_bits.push_back(lcr[4] ? (ones % 2 == 1) : (ones % 2 == 0));
        m_bits.push_back(1'b1);
        if (lcr[2]) m_bits.push_back(1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int   div;
        int   pre_size;
        logic req;
        if (!rst_n) begin
            m_q.delete();
            m_bits.delete();
            m_level = 1'b1;
            m_busy  = 1'b0;
            m_ack   = 1'b0;
            m_ier   = 8'h00;
            m_lcr   = 8'h03;
            m_dll   = 8'h00;
            m_dlm   = 8'h00;
            m_rem   = 0;
        end else begin
            div      = int'({m_dlm, m_dll});
            pre_size = m_q.size();
            req      = cyc && stb && !m_ack;
            if (div != 0) begin
                if (m_busy) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        if (m_bits.size() > 0) begin
                            m_level = m_bits.pop_front();
                            m_rem   = 16 * div;
                        end else begin
                            m_busy  = 1'b0;
                            m_level = 1'b1;
                        end
                    end
                end
                if (!m_busy && m_q.size() > 0) begin
                    build_frame(m_q.pop_front(), m_lcr);
                    m_level = 1'b0;
                    m_rem   = 16 * div;
                    m_busy  = 1'b1;
                end
            end
            if (req && we) begin
                case (addr[2:0])
                    3'd0: begin
                        if (m_lcr[7])                    m_dll = dat_i;
                        else if (pre_size < FIFO_DEPTH)  m_q.push_back(dat_i);
                    end
                    3'd1: begin
                        if (m_lcr[7]) m_dlm = dat_i;
                        else          m_ier = dat_i;
                    end
                    3'd3: m_lcr = dat_i;
                    default: ;
                endcase
            end
            m_ack = req;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("stx_vs_model", stx, m_level);
        check("int_vs_model", irq, m_ier[1] && (m_q.size() == 0));
        check("ack_vs_model", ack, m_ack);
        if (!m_ack) check("dat_idle_zero", dat_o, 8'h00);
    end

    task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = {2'b00, a};
        dat_i = d;
        we    = 1'b1;
        cyc   = 1'b1;
        stb   = 1'b1;
        @(negedge clk);
        check("wr_ack", ack, 1);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = {2'b00, a};
        we   = 1'b0;
        cyc  = 1'b1;
        stb  = 1'b1;
        @(negedge clk);
        check("rd_ack", ack, 1);
        d   = dat_o;
        cyc = 1'b0;
        stb = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] v;
        wb_read(a, v);
        check(name, v, exp);
    endtask

    // Samples each bit mid-period (divisor 1), starting at the next start bit.
    task automatic capture(input string name, input int nbits, input logic [11:0] exp);
        logic [11:0] bits;
        int          n;
        bits = '1;
        n    = 0;
        while (stx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (stx !== 1'b0) begin
            check({name, "_start_seen"}, stx, 0);
        end else begin
            repeat (8) @(negedge clk);
            bits[0] = stx;
            for (int i = 1; i < nbits; i++) begin
                repeat (16) @(negedge clk);
                bits[i] = stx;
            end
            check(name, bits, exp);
        end
    endtask

    task automatic wait_idle();
        logic [7:0] v;
        int         n;
        n = 0;
        do begin
            wb_read(ADDR_LSR, v);
            n++;
        end while (v[6] !== 1'b1 && n < 400);
        check("idle_lsr", v, 8'h60);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (stx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, stx, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_low;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_stx", stx, 1);
        check("reset_int", irq, 0);
        check("reset_ack", ack, 0);
        read_check("reset_lsr", ADDR_LSR, 8'h60);
        read_check("reset_iir", ADDR_IIR, 8'h01);
        read_check("reset_lcr", ADDR_LCR, 8'h03);

        // 8N1, divisor 1
        wb_write(ADDR_LCR, 8'h83);
        wb_write(ADDR_THR, 8'h01);
        wb_write(ADDR_IER, 8'h00);
        wb_write(ADDR_LCR, 8'h03);
        wb_write(ADDR_THR, 8'h55);
        capture("frame_55_8n1", 10, 12'hEAA);
        wait_idle();

        // 8E1 then 8O2 on 0x07
        wb_write(ADDR_LCR, 8'h1B);
        wb_write(ADDR_THR, 8'h07);
        capture("frame_07_8e1", 11, 12'hE0E);
        wait_idle();
        wb_write(ADDR_LCR, 8'h0F);
        wb_write(ADDR_THR, 8'h07);
        capture("frame_07_8o2", 12, 12'hC0E);
        wait_idle();
        wb_write(ADDR_LCR, 8'h03);

        // THRE interrupt
        wb_write(ADDR_IER, 8'h02);
        check("int_set_empty", irq, 1);
        read_check("iir_thre", ADDR_IIR, 8'h02);
        wb_write(ADDR_THR, 8'hA5);
        check("int_clear_on_push", irq, 0);
        wait_start("int_pop_start");
        check("int_at_last_pop", irq, 1);
        wait_idle();

        // Divisor 0: fill, overflow, then release
        wb_write(ADDR_LCR, 8'h83);
        wb_write(ADDR_THR, 8'h00);
        wb_write(ADDR_LCR, 8'h03);
        for (int i = 0; i < 17; i++) wb_write(ADDR_THR, 8'(i + 1));
        read_check("lsr_overflow", ADDR_LSR, 8'h02);
        read_check("lsr_overflow_cleared", ADDR_LSR, 8'h00);
        wb_write(ADDR_LCR, 8'h83);
        wb_write(ADDR_THR, 8'h01);
        for (int i = 0; i < 16; i++) begin
            b = 8'(i + 1);
            capture("burst_frame", 10, {3'b111, b, 1'b0});
        end
        saw_low = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (stx === 1'b0) saw_low = 1'b1;
        end
        check("no_17th_frame", saw_low, 0);
        wb_write(ADDR_LCR, 8'h03);
        read_check("burst_done_lsr", ADDR_LSR, 8'h60);

        // Reset during DATA
        wb_write(ADDR_THR, 8'hF0);
        wb_write(ADDR_THR, 8'hF0);
        wait_start("rst_frame_start");
        repeat (24) @(negedge clk);
        check("mid_data_low", stx, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("stx_async_reset", stx, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        read_check("post_reset_lsr", ADDR_LSR, 8'h60);
        read_check("post_reset_lcr", ADDR_LCR, 8'h03);
        saw_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (stx === 1'b0) saw_low = 1'b1;
        end
        check("post_reset_idle", saw_low, 0);
        check("post_reset_int", irq, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
